// File: rtl/spi_readback_if.sv
// Command/register-file/pad bundle for spi_readback.
// The frontend and register file sit on the master side; the readback block is the slave.
interface spi_readback_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7
);
  logic              cmd_valid;
  logic              cmd_is_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_strobe;
  logic              poci;
  logic              poci_oe;
  logic              busy;

  modport slave (
    input  cmd_valid, cmd_is_write, cmd_addr, rdata,
    output rd_addr, rd_strobe, poci, poci_oe, busy
  );

  modport master (
    output cmd_valid, cmd_is_write, cmd_addr, rdata,
    input  rd_addr, rd_strobe, poci, poci_oe, busy
  );
endinterface

// File: rtl/spi_readback.sv
// SPI read-return path: loads register data on a read command and shifts it out MSB-first.
// Define SPI_BURST_EN for auto-increment burst reads until chip select is released.
module spi_readback #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7
) (
  input  logic           spi_clk,
  input  logic           rstn,
  input  logic           cs,
  spi_readback_if.slave  bus
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  bitcnt_q, bitcnt_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;

  logic              clr_n;
  logic [ADDR_W-1:0] next_addr;
  logic              rd_strobe;
  logic              in_shift;

  // Chip select high is a transaction-level clear, merged with reset.
  assign clr_n = rstn & ~cs;

  always_ff @(posedge spi_clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      bitcnt_q   <= '0;
      cur_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bitcnt_q   <= bitcnt_d;
      cur_addr_q <= cur_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bitcnt_d   = bitcnt_q;
    cur_addr_d = cur_addr_q;
    rd_strobe  = 1'b0;
    next_addr  = cur_addr_q + ADDR_W'(1);

    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid && !bus.cmd_is_write) begin
          shreg_d    = bus.rdata;
          cur_addr_d = bus.cmd_addr;
          bitcnt_d   = '0;
          rd_strobe  = 1'b1;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        if (bitcnt_q != LAST) begin
          shreg_d  = shreg_q << 1;
          bitcnt_d = bitcnt_q + CNT_W'(1);
        end else begin
`ifdef SPI_BURST_EN
          shreg_d    = bus.rdata;
          cur_addr_d = next_addr;
          bitcnt_d   = '0;
          rd_strobe  = 1'b1;
`else
          // Last bit already out: drain to zero and park the counter.
          shreg_d  = shreg_q << 1;
          bitcnt_d = bitcnt_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_shift      = (state_q == SHIFT);
  assign bus.rd_addr   = (!in_shift && bus.cmd_valid) ? bus.cmd_addr : next_addr;
  assign bus.rd_strobe = rd_strobe;
  assign bus.busy      = in_shift;
  assign bus.poci_oe   = in_shift & ~cs;
  assign bus.poci      = shreg_q[DATA_W-1] & bus.poci_oe;

endmodule

// File: tb/tb_spi_readback.sv
// Directed bench for spi_readback; expectations follow the SPI_BURST_EN setting of the build.
module tb_spi_readback;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 7;

  logic spi_clk = 1'b0;
  logic rstn    = 1'b1;
  logic cs      = 1'b0;

  spi_readback_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  logic [7:0] mem [0:127];
  assign bus.rdata = mem[bus.rd_addr];

  spi_readback #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .spi_clk (spi_clk),
    .rstn    (rstn),
    .cs      (cs),
    .bus     (bus)
  );

  always #5 spi_clk = ~spi_clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, ".poci"},      32'(bus.poci),      32'h0);
    check({name, ".poci_oe"},   32'(bus.poci_oe),   32'h0);
    check({name, ".busy"},      32'(bus.busy),      32'h0);
    check({name, ".rd_strobe"}, 32'(bus.rd_strobe), 32'h0);
    check({name, ".rd_addr"},   32'(bus.rd_addr),   32'h01);
  endtask

  // Called at a negedge with cs low: issues the command pulse, then samples
  // nbits data bits mid-cycle (each value is what the controller takes at the next rising edge).
  task automatic txn(input logic wr, input logic [6:0] addr, input int nbits,
                     output logic [15:0] bits, output int strb,
                     output logic [3:0][6:0] saddr, output int oe_c, output int busy_c);
    bits = '0; strb = 0; saddr = '0; oe_c = 0; busy_c = 0;
    bus.cmd_valid    = 1'b1;
    bus.cmd_is_write = wr;
    bus.cmd_addr     = addr;
    #1;
    if (bus.rd_strobe) begin saddr[0] = bus.rd_addr; strb++; end
    @(negedge spi_clk);
    bus.cmd_valid    = 1'b0;
    bus.cmd_is_write = 1'b0;
    bus.cmd_addr     = '0;
    for (int i = 0; i < nbits; i++) begin
      #1;
      bits   = {bits[14:0], bus.poci};
      oe_c   += int'(bus.poci_oe);
      busy_c += int'(bus.busy);
      if (bus.rd_strobe) begin
        if (strb < 4) saddr[strb] = bus.rd_addr;
        strb++;
      end
      @(negedge spi_clk);
    end
  endtask

  typedef struct {
    logic       wr;
    logic [6:0] addr;
    logic [7:0] exp0;
    logic [7:0] exp1;
    int         exp_strb;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [15:0]     bits;
    int              strb, oe_c, busy_c;
    logic [3:0][6:0] saddr;
    int              exp_act;

    for (int a = 0; a < 128; a++) mem[a] = 8'(a) ^ 8'h3C;
    mem[5] = 8'hA5;
    mem[6] = 8'h81;

`ifdef SPI_BURST_EN
    vecs[0] = '{1'b0, 7'h05, 8'hA5, 8'h81, 3};
    vecs[1] = '{1'b0, 7'h7E, 8'h42, 8'h43, 3};
    vecs[2] = '{1'b1, 7'h10, 8'h00, 8'h00, 0};
    vecs[3] = '{1'b0, 7'h00, 8'h3C, 8'h3D, 3};
    vecs[4] = '{1'b0, 7'h06, 8'h81, 8'h3B, 3};
`else
    vecs[0] = '{1'b0, 7'h05, 8'hA5, 8'h00, 1};
    vecs[1] = '{1'b0, 7'h7E, 8'h42, 8'h00, 1};
    vecs[2] = '{1'b1, 7'h10, 8'h00, 8'h00, 0};
    vecs[3] = '{1'b0, 7'h00, 8'h3C, 8'h00, 1};
    vecs[4] = '{1'b0, 7'h06, 8'h81, 8'h00, 1};
`endif

    bus.cmd_valid    = 1'b0;
    bus.cmd_is_write = 1'b0;
    bus.cmd_addr     = '0;

    #1 rstn = 1'b0;
    #1 check_idle_outputs("reset");
    repeat (2) @(negedge spi_clk);
    rstn = 1'b1;
    cs   = 1'b1;
    #1 check_idle_outputs("cs_high");
    @(negedge spi_clk);

    for (int v = 0; v < 5; v++) begin
      cs = 1'b0;
      repeat (2) @(negedge spi_clk);
      txn(vecs[v].wr, vecs[v].addr, 16, bits, strb, saddr, oe_c, busy_c);
      exp_act = vecs[v].wr ? 0 : 16;
      check($sformatf("v%0d.byte0", v), 32'(bits[15:8]), 32'(vecs[v].exp0));
      check($sformatf("v%0d.byte1", v), 32'(bits[7:0]),  32'(vecs[v].exp1));
      check($sformatf("v%0d.strobes", v), 32'(strb), 32'(vecs[v].exp_strb));
      check($sformatf("v%0d.oe_cycles", v), 32'(oe_c), 32'(exp_act));
      check($sformatf("v%0d.busy_cycles", v), 32'(busy_c), 32'(exp_act));
      for (int k = 0; k < vecs[v].exp_strb && k < strb && k < 4; k++)
        check($sformatf("v%0d.strobe_addr%0d", v, k), 32'(saddr[k]),
              32'(7'(vecs[v].addr + 7'(k))));
      cs = 1'b1;
      #1 check_idle_outputs($sformatf("v%0d.cs_release", v));
      @(negedge spi_clk);
    end

    // Abort after three data bits, then a clean read of 0x06.
    cs = 1'b0;
    repeat (2) @(negedge spi_clk);
    txn(1'b0, 7'h05, 3, bits, strb, saddr, oe_c, busy_c);
    check("abort.first3", 32'(bits[2:0]), 32'b101);
    cs = 1'b1;
    #1 check_idle_outputs("abort");
    @(negedge spi_clk);
    cs = 1'b0;
    @(negedge spi_clk);
    #1 check("abort.rd_addr_clean", 32'(bus.rd_addr), 32'h01);
    @(negedge spi_clk);
    txn(1'b0, 7'h06, 8, bits, strb, saddr, oe_c, busy_c);
    check("after_abort.byte", 32'(bits[7:0]), 32'h81);
    check("after_abort.strobes", 32'(strb), 32'd1);
    cs = 1'b1;
    @(negedge spi_clk);

    // Reset pulse during the second byte, then a read of 0x00.
    cs = 1'b0;
    repeat (2) @(negedge spi_clk);
    txn(1'b0, 7'h05, 10, bits, strb, saddr, oe_c, busy_c);
    rstn = 1'b0;
    #1 check_idle_outputs("mid_reset");
    @(negedge spi_clk);
    rstn = 1'b1;
    @(negedge spi_clk);
    txn(1'b0, 7'h00, 16, bits, strb, saddr, oe_c, busy_c);
    check("after_reset.byte0", 32'(bits[15:8]), 32'h3C);
    check("after_reset.byte1", 32'(bits[7:0]),  32'(vecs[3].exp1));
    check("after_reset.strobes", 32'(strb), 32'(vecs[3].exp_strb));
    cs = 1'b1;
    @(negedge spi_clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
